// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } uart_rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_OVERSAMPLE = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning: 2-FF synchronizer for the serial line and rising-edge
// detector that turns the oversample clock level into a one-cycle tick.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic rxclk,
  output logic rx_sync,
  output logic tick
);

  logic rx_meta_p0;
  logic rx_sync_p1;
  logic rxclk_p0;

  // Stage p0/p1: line idles high, so reset to 1 keeps the FSM quiet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rxclk_p0   <= 1'b0;
    end else begin
      rx_meta_p0 <= rx;
      rx_sync_p1 <= rx_meta_p0;
      rxclk_p0   <= rxclk;
    end
  end

  assign rx_sync = rx_sync_p1;
  assign tick    = rxclk & ~rxclk_p0;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled frame FSM, shift register and a valid/ready
// holding register carrying parity, framing and overrun status.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int PARITY     = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic b);
    return (^d) ^ b ^ logic'(PARITY == PAR_ODD);
  endfunction

  logic rxs;
  logic tick;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rxclk   (rxclk),
    .rx_sync (rxs),
    .tick    (tick)
  );

  uart_rx_state_t       state, state_nx;
  logic [TW-1:0]        tcnt, tcnt_nx;
  logic [BW-1:0]        bcnt, bcnt_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 perr_q, perr_nx;
  logic                 done;
  logic                 ferr_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= tcnt_nx;
      bcnt  <= bcnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift  <= shift_nx;
    perr_q <= perr_nx;
  end

  // All bit timing advances on tick only; the start sample lands mid-bit
  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    bcnt_nx  = bcnt;
    shift_nx = shift;
    perr_nx  = perr_q;
    done     = 1'b0;
    ferr_nx  = 1'b0;
    if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (!rxs) begin
            state_nx = S_START;
            tcnt_nx  = '0;
          end
        end
        S_START: begin
          if (tcnt == T_HALF) begin
            tcnt_nx  = '0;
            bcnt_nx  = '0;
            perr_nx  = 1'b0;
            state_nx = rxs ? S_IDLE : S_DATA;
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tcnt == T_FULL) begin
            tcnt_nx  = '0;
            shift_nx = {rxs, shift[DATA_BITS-1:1]};
            bcnt_nx  = bcnt + 1'b1;
            if (bcnt == B_LAST)
              state_nx = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tcnt == T_FULL) begin
            tcnt_nx  = '0;
            perr_nx  = parity_bad(shift, rxs);
            state_nx = S_STOP;
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tcnt == T_FULL) begin
            tcnt_nx  = '0;
            done     = 1'b1;
            ferr_nx  = ~rxs;
            state_nx = rxs ? S_IDLE : S_BREAK;
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // A completing frame wins over a plain accept; a full register drops it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= shift;
        parity_err <= (PARITY != PAR_NONE) && perr_q;
        frame_err  <= ferr_nx;
        rx_valid   <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receiver stage fed by the baud generator. It consumes the generator's 8×-oversample receive clock (`rxclk`, a toggling level in the `clk` domain) and the raw serial line. It recovers 8-N-1 / 8-E-1 / 8-O-1 frames, sampling each bit at its midpoint. Received bytes go to the downstream consumer through a valid/ready holding register, with parity, framing and overrun status.

## Interface

Parameters:
- `DATA_BITS`, 8: payload bits per frame, LSB first.
- `OVERSAMPLE`, 8: `rxclk` rising edges per bit period. Must be even and ≥4.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `rxclk`  in  1  oversample clock level from the baud generator; sampled as data in `clk` domain.
- `rx`  in  1  raw serial line; idle high; asynchronous.
- `rx_data`  out  DATA_BITS  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts on a `clk` edge with `rx_valid`&`rx_ready`.
- `parity_err`  out  1  parity mismatch for the held byte.
- `frame_err`  out  1  stop bit sampled 0 for the held byte.
- `overrun`  out  1  sticky: a frame completed while the register was full.
- `busy`  out  1  FSM not in IDLE.

## Operation

- `rx` passes through a 2-FF synchronizer; reset value 1.
- `rxclk` is registered once. `tick` = `rxclk` & ~`rxclk_q`, i.e. one `clk` cycle per rising edge.
- All bit timing advances only on `tick`. A 3-bit tick counter `tcnt` and a bit counter `bcnt` are used.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on `tick` with synced `rx`=0 → START, `tcnt`=0.
  - START: after OVERSAMPLE/2 ticks, sample `rx`.
    - 0 → DATA, `tcnt`=0, `bcnt`=0.
    - 1 → IDLE (glitch rejected; no flags change).
  - DATA: every OVERSAMPLE ticks, shift `rx` into shift[DATA_BITS-1] with a right shift, so LSB first.
    - After DATA_BITS samples → PARITY if PARITY≠0, else STOP.
  - PARITY: after OVERSAMPLE ticks, sample the parity bit.
    - Error when XOR(payload, bit) ≠ 0 for even parity.
    - Error when XOR(payload, bit) ≠ 1 for odd parity.
  - STOP: after OVERSAMPLE ticks, sample the stop bit and complete the frame.
    - Next state → IDLE if the sample is 1.
    - Next state → BREAK if the sample is 0.
  - BREAK: wait until synced `rx`=1 on a `tick`, then → IDLE. No new frames are started while in BREAK.
- Frame completion, with `rx_valid`=0, or `rx_valid`=1 and `rx_ready`=1 in the same cycle:
  - load `rx_data`, `parity_err`, `frame_err`;
  - set `rx_valid`=1.
- Frame completion with `rx_valid`=1 and `rx_ready`=0:
  - the new byte is dropped;
  - the held byte and its flags are unchanged;
  - `overrun` is set to 1.
- Accept (`rx_valid`&`rx_ready`) with no completion in the same cycle:
  - `rx_valid`→0;
  - `overrun`→0;
  - `parity_err`/`frame_err` keep their values, meaningless while invalid.
- Reset assertion at any time:
  - all state returns to IDLE;
  - an in-flight frame is discarded;
  - all outputs go to reset values.

## Timing

- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- Input latency: `rx` → FSM is 2 `clk`. `rxclk` edge → `tick` is 1 `clk`.
- Start edge detection is quantised to one tick, so the sample point falls OVERSAMPLE/2 to OVERSAMPLE/2+1 ticks after the true edge.
- `rx_valid` rises on the `clk` edge of the `tick` that samples the stop bit. Data and flags change on that same edge.
- `rx_valid` stays high until accepted. Acceptance takes effect on the next `clk` edge.
- `busy`=1 from entry to START through exit of STOP/BREAK.

## Structure

- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t`;
  - parity constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - default `OVERSAMPLE`.
- Sub-module `uart_rx_sync`: the 2-FF `rx` synchronizer plus the `rxclk` rising-edge → `tick` detector.
- Top level holds the FSM, counters, shift register and output register.

## Test plan

- Clean frame, PARITY=0, byte 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) → `rx_data`=0xA5, `rx_valid`=1, both error flags 0. Then `rx_ready` for 1 cycle → `rx_valid`=0.
- PARITY=1, byte 0x03 with parity bit 1 (wrong) → `rx_data`=0x03, `parity_err`=1. Same byte with parity bit 0 → `parity_err`=0. Repeat with PARITY=2 and the polarities inverted.
- Line low for 3 ticks, then high → stays/returns to IDLE, `busy`=0 afterwards, `rx_valid` stays 0.
- Stop bit 0 on byte 0x55, line then held low for 40 ticks, then idle, then a clean frame 0x3C → first frame: `frame_err`=1. No extra frames during the low period. After accept, 0x3C is received with `frame_err`=0.
- Two back-to-back frames 0x11 and 0x22 with `rx_ready`=0 → `rx_data`=0x11, `overrun`=1. Accept → `overrun`=0, `rx_valid`=0.
- Assert `rst` mid-DATA (after 4 bits) → all outputs at reset values. After release, the next full frame 0x7E is received correctly.
